// File: rtl/wb_spi_slave.sv
// ============================================================================
//  Module   : wb_spi_slave
//  Purpose  : Wishbone-attached SPI mode-0 target with one RX and one TX byte.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_spi_slave #(
  parameter logic [7:0]  FILL_BYTE   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        spi_cs_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  localparam logic [1:0] c_ADR_RXDATA = 2'd0;
  localparam logic [1:0] c_ADR_TXDATA = 2'd1;
  localparam logic [1:0] c_ADR_STATUS = 2'd2;
  localparam logic [1:0] c_ADR_CTRL   = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_full_q, rx_full_d;
  logic        tx_empty_q, tx_empty_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic       w_sck_s, w_cs_s, w_mosi_s;
  logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic [1:0] w_adr;
  logic       w_ack_rd, w_ack_wr;
  logic [7:0] w_rx_byte;
  logic [7:0] w_status;
  logic       w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  // The cs chain resets to "asserted" so a frame already in progress at
  // reset release never produces a cs_fall; only a fresh frame does.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign w_cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign w_mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~sck_prev_q;
  assign w_sck_fall = ~w_sck_s & sck_prev_q;
  assign w_cs_fall  = ~w_cs_s & cs_prev_q;
  assign w_cs_rise  = w_cs_s & ~cs_prev_q;

  assign w_adr     = wb_adr_i[3:2];
  assign w_ack_rd  = ack_q & wb_stb_i & wb_cyc_i & ~wb_we_i;
  assign w_ack_wr  = ack_q & wb_stb_i & wb_cyc_i & wb_we_i;
  assign w_rx_byte = {rx_shift_q[6:0], w_mosi_s};
  assign w_status  = {3'b000, (state_q == ST_ACTIVE), (bit_cnt_q != 3'd0),
                      overrun_q, tx_empty_q, rx_full_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_data_q  <= '0;
      rx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      overrun_q  <= 1'b0;
      ctrl_q     <= '0;
      miso_q     <= 1'b1;
      miso_oe_q  <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_data_q  <= tx_data_d;
      rx_full_q  <= rx_full_d;
      tx_empty_q <= tx_empty_d;
      overrun_q  <= overrun_d;
      ctrl_q     <= ctrl_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  // CPU clears are applied first and the frame logic afterwards so that
  // byte completion and new overruns win; a TXDATA write is applied last so
  // a concurrent reload consumes the old queue state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    tx_data_d  = tx_data_q;
    rx_full_d  = rx_full_q;
    tx_empty_d = tx_empty_q;
    overrun_d  = overrun_q;
    ctrl_d     = ctrl_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    ack_d      = wb_stb_i & wb_cyc_i & ~ack_q;
    dat_d      = '0;

    if (ack_d && !wb_we_i) begin
      case (w_adr)
        c_ADR_RXDATA: dat_d = {24'd0, rx_data_q};
        c_ADR_STATUS: dat_d = {24'd0, w_status};
        c_ADR_CTRL:   dat_d = {30'd0, ctrl_q};
        default:      dat_d = '0;
      endcase
    end

    if (w_ack_rd && w_adr == c_ADR_RXDATA) rx_full_d = 1'b0;
    if (w_ack_wr && w_adr == c_ADR_STATUS && wb_dat_i[2]) overrun_d = 1'b0;
    if (w_ack_wr && w_adr == c_ADR_CTRL) ctrl_d = wb_dat_i[1:0];

    case (state_q)
      ST_IDLE: begin
        if (w_cs_fall) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          miso_oe_d = 1'b1;
          if (!tx_empty_q) begin
            tx_shift_d = tx_data_q;
            tx_empty_d = 1'b1;
          end else begin
            tx_shift_d = FILL_BYTE;
          end
          miso_d = tx_shift_d[7];
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
        end else if (w_sck_rise) begin
          rx_shift_d = w_rx_byte;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (!rx_full_q) begin
              rx_data_d = w_rx_byte;
              rx_full_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (w_sck_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else if (!tx_empty_q) begin
            tx_shift_d = tx_data_q;
            tx_empty_d = 1'b1;
          end else begin
            tx_shift_d = FILL_BYTE;
          end
          miso_d = tx_shift_d[7];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_ack_wr && w_adr == c_ADR_TXDATA) begin
      tx_data_d  = wb_dat_i[7:0];
      tx_empty_d = 1'b0;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign intr        = (ctrl_q[0] & rx_full_q) | (ctrl_q[1] & tx_empty_q) | overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_spi_slave.sv
// ============================================================================
//  Module   : tb_wb_spi_slave
//  Purpose  : Self-checking bench driving wb_spi_slave as SPI master and CPU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_spi_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o;
  logic        intr;
  logic        spi_cs_n = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];

  always #5 clk = ~clk;

  wb_spi_slave #(
    .FILL_BYTE   (8'hFF),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_stb_i    (wb_stb_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_ack_o    (wb_ack_o),
    .intr        (intr),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_cycle(input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, output logic [31:0] rdat);
    logic got;
    got      = 1'b0;
    rdat     = '0;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = wdat;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        got  = 1'b1;
        rdat = wb_dat_o;
      end
    end
    if (!got) check_val("wb_ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    check_val("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_cycle(adr, 1'b1, wdat, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_cycle(adr, 1'b0, 32'd0, rd);
    check_val(tag, rd, exp);
  endtask

  // Reads RXDATA and compares against the oldest byte the bench expects captured.
  task automatic rx_pop_check(input string tag);
    logic [31:0] rd;
    logic [7:0]  exp;
    wb_cycle(32'h0, 1'b0, 32'd0, rd);
    if (exp_rx_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_rx_q.pop_front();
      check_val(tag, rd, {24'd0, exp});
    end
  endtask

  // Master side: mode 0, half period of 4 clk, MSB first.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (4) @(negedge clk);
      mi[7-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte_check(input string tag, input logic [7:0] mo);
    logic [7:0] mi;
    logic [7:0] exp;
    spi_bits(mo, 8, mi);
    if (exp_miso_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_miso_q.pop_front();
      check_val(tag, {24'd0, mi}, {24'd0, exp});
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check_val("rst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("rst_miso", {31'd0, spi_miso}, 32'd1);
    check_val("rst_intr", {31'd0, intr}, 32'd0);
    check_val("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check_val("rst_dat", wb_dat_o, 32'd0);
    wb_read_check("rst_status", 32'h8, 32'h02);

    // Queued reply byte with a single-byte frame.
    wb_write(32'h4, 32'hA5);
    wb_read_check("status_tx_queued", 32'h8, 32'h00);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    cs_begin();
    check_val("frame_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("frame_miso_oe_on", {31'd0, spi_miso_oe}, 32'd1);
    spi_byte_check("miso_A5", 8'h3C);
    cs_end();
    check_val("idle_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    wb_read_check("status_after_byte", 32'h8, 32'h03);
    rx_pop_check("rx_3C");
    wb_read_check("status_after_read", 32'h8, 32'h02);

    // Three bytes, no reads: first byte kept, later ones overrun.
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h01);
    cs_begin();
    spi_byte_check("miso_fill0", 8'h01);
    spi_byte_check("miso_fill1", 8'h02);
    spi_byte_check("miso_fill2", 8'h03);
    cs_end();
    check_val("overrun_intr", {31'd0, intr}, 32'd1);
    wb_read_check("status_overrun", 32'h8, 32'h07);
    rx_pop_check("rx_keep_01");
    wb_write(32'h8, 32'h04);
    wb_read_check("status_w1c", 32'h8, 32'h02);
    check_val("intr_cleared", {31'd0, intr}, 32'd0);

    // Partial frame aborted after 5 bits.
    cs_begin();
    spi_bits(8'hF0, 5, mi);
    repeat (4) @(negedge clk);
    wb_read_check("status_busy", 32'h8, 32'h1A);
    cs_end();
    check_val("abort_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("abort_miso", {31'd0, spi_miso}, 32'd1);
    wb_read_check("status_abort", 32'h8, 32'h02);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h5A);
    cs_begin();
    spi_byte_check("miso_after_abort", 8'h5A);
    cs_end();
    rx_pop_check("rx_5A");

    // RX interrupt timing relative to the 8th sck rise.
    wb_write(32'hC, 32'h01);
    wb_read_check("ctrl_rb", 32'hC, 32'h01);
    exp_rx_q.push_back(8'hC3);
    cs_begin();
    spi_bits(8'hC3, 7, mi);
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    repeat (2) @(negedge clk);
    check_val("intr_not_early", {31'd0, intr}, 32'd0);
    @(negedge clk);
    check_val("intr_rx_set", {31'd0, intr}, 32'd1);
    @(negedge clk);
    spi_sck = 1'b0;
    cs_end();
    rx_pop_check("rx_C3");
    check_val("intr_rx_cleared", {31'd0, intr}, 32'd0);

    // TX-empty interrupt.
    wb_write(32'hC, 32'h02);
    check_val("intr_tx_empty", {31'd0, intr}, 32'd1);
    wb_write(32'h4, 32'h96);
    check_val("intr_tx_loaded", {31'd0, intr}, 32'd0);
    wb_write(32'hC, 32'h00);

    // Reset in the middle of a frame with cs held low.
    cs_begin();
    spi_bits(8'hE7, 4, mi);
    check_val("pre_rst_miso_oe", {31'd0, spi_miso_oe}, 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_val("midrst_miso", {31'd0, spi_miso}, 32'd1);
    check_val("midrst_intr", {31'd0, intr}, 32'd0);
    check_val("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
    reset = 1'b0;
    spi_bits(8'h70, 4, mi);
    check_val("midrst_still_idle", {31'd0, spi_miso_oe}, 32'd0);
    cs_end();
    wb_read_check("status_after_midrst", 32'h8, 32'h02);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h81);
    cs_begin();
    spi_byte_check("miso_recover", 8'h81);
    cs_end();
    rx_pop_check("rx_81");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
